fetch_2: RTL

Second fetch stage. Takes PCs from `fetch_1`, issues instruction-memory requests, pairs each in-order response with its PC and buffers the result in a small instruction queue feeding decode. It limits requests in flight so that every response has guaranteed queue space. It discards stale responses after a flush.

---
 rtl/fetch_2.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fetch_2.sv
// Second fetch stage: issues instruction-memory requests, pairs in-order responses with their PC
// and queues them for decode. Optional build macro FETCH_2_MISALIGN_CHECK_EN traps misaligned PCs.
module fetch_2 #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int PHY_ADDR_SIZE   = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     pc_valid_i,
  input  logic [PHY_ADDR_SIZE-1:0] pc_i,
  output logic                     pc_ready_o,
  output logic                     imem_req_o,
  output logic [PHY_ADDR_SIZE-1:0] imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [31:0]              imem_rdata_i,
  input  logic                     imem_err_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [PHY_ADDR_SIZE-1:0] instr_pc_o,
  output logic                     instr_fault_o,
  input  logic                     instr_ready_i
);

  localparam int QAW = $clog2(FIFO_DEPTH);
  localparam int QCW = QAW + 1;
  localparam int OAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int UW  = QCW + 1;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [OCW-1:0]           discard_q, discard_d;

  logic                     req_vld_p0;
  logic                     req_mis_p0;
  logic [PHY_ADDR_SIZE-1:0] req_pc_p0;

  logic [PHY_ADDR_SIZE-1:0] opc_mem [MAX_OUTSTANDING];
  logic [OAW-1:0]           owr_ptr, ord_ptr;
  logic [OCW-1:0]           out_cnt;

  logic [31:0]              iq_instr [FIFO_DEPTH];
  logic [PHY_ADDR_SIZE-1:0] iq_pc    [FIFO_DEPTH];
  logic                     iq_fault [FIFO_DEPTH];
  logic [QAW-1:0]           iq_wr, iq_rd;
  logic [QCW-1:0]           iq_cnt;

  logic                     run, gnt, rsp, mis_pc, mis_fire, req_fire, accept;
  logic                     opush, opop, ipush, ipop;
  logic [UW-1:0]            used;
  logic [OCW-1:0]           out_after;
  logic [31:0]              push_instr;
  logic [PHY_ADDR_SIZE-1:0] push_pc;
  logic                     push_fault;

  function automatic logic [OAW-1:0] oinc(input logic [OAW-1:0] p);
    return (p == OAW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    run         = (state_q == RUN);
    imem_req_o  = run && req_vld_p0 && !req_mis_p0;
    imem_addr_o = imem_req_o ? req_pc_p0 : '0;
    gnt         = imem_req_o && imem_gnt_i;
    rsp         = run && imem_rvalid_i;
`ifdef FETCH_2_MISALIGN_CHECK_EN
    mis_pc      = |pc_i[1:0];
    // A trapped PC waits for older requests to return so it lands in program order.
    mis_fire    = run && req_vld_p0 && req_mis_p0 && (out_cnt == '0);
`else
    mis_pc      = 1'b0;
    mis_fire    = 1'b0;
`endif
    req_fire    = gnt || mis_fire;
    used        = UW'(req_vld_p0) + UW'(out_cnt) + UW'(iq_cnt);
    out_after   = out_cnt + OCW'(gnt) - OCW'(rsp);
    // Same-cycle pops are ignored, so every accepted PC already owns a queue slot.
    pc_ready_o  = run && !flush_i && (!req_vld_p0 || req_fire)
                  && (used < UW'(FIFO_DEPTH)) && (out_after < OCW'(MAX_OUTSTANDING));
    accept      = pc_valid_i && pc_ready_o;

    instr_valid_o = (iq_cnt != '0);
    opush       = gnt && !flush_i;
    opop        = rsp && !flush_i;
    ipush       = (rsp || mis_fire) && !flush_i;
    ipop        = instr_valid_o && instr_ready_i && !flush_i;

    push_fault  = rsp ? imem_err_i : 1'b1;
    push_instr  = (rsp && !imem_err_i) ? imem_rdata_i : '0;
    push_pc     = rsp ? opc_mem[ord_ptr] : req_pc_p0;

    instr_o       = instr_valid_o ? iq_instr[iq_rd] : '0;
    instr_pc_o    = instr_valid_o ? iq_pc[iq_rd]    : '0;
    instr_fault_o = instr_valid_o && iq_fault[iq_rd];
  end

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    case (state_q)
      RUN: begin
        if (flush_i) begin
          discard_d = out_after;
          state_d   = (out_after != '0) ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (imem_rvalid_i) begin
          discard_d = discard_q - 1'b1;
          if (discard_q == OCW'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // p0: request register, outstanding PC queue and instruction queue control
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      discard_q  <= '0;
      req_vld_p0 <= 1'b0;
      req_mis_p0 <= 1'b0;
      owr_ptr    <= '0;
      ord_ptr    <= '0;
      out_cnt    <= '0;
      iq_wr      <= '0;
      iq_rd      <= '0;
      iq_cnt     <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (flush_i) begin
        req_vld_p0 <= 1'b0;
        req_mis_p0 <= 1'b0;
        owr_ptr    <= '0;
        ord_ptr    <= '0;
        out_cnt    <= '0;
        iq_wr      <= '0;
        iq_rd      <= '0;
        iq_cnt     <= '0;
      end else begin
        if (accept) begin
          req_vld_p0 <= 1'b1;
          req_mis_p0 <= mis_pc;
        end else if (req_fire) begin
          req_vld_p0 <= 1'b0;
        end
        if (opush) owr_ptr <= oinc(owr_ptr);
        if (opop)  ord_ptr <= oinc(ord_ptr);
        out_cnt <= out_cnt + OCW'(opush) - OCW'(opop);
        if (ipush) iq_wr <= iq_wr + 1'b1;
        if (ipop)  iq_rd <= iq_rd + 1'b1;
        iq_cnt <= iq_cnt + QCW'(ipush) - QCW'(ipop);
      end
    end
  end

  // p0: datapath storage, validity tracked by the control above
  always_ff @(posedge clk_i) begin
    if (accept) req_pc_p0 <= pc_i;
    if (opush)  opc_mem[owr_ptr] <= req_pc_p0;
    if (ipush) begin
      iq_instr[iq_wr] <= push_instr;
      iq_pc[iq_wr]    <= push_pc;
      iq_fault[iq_wr] <= push_fault;
    end
  end

endmodule
